display_update_scheduler: RTL and testbench

- Scheduler between measurement producers (voltage path, frequency path) and the 3-digit seven-segment display driver.
- On a fixed refresh tick (0.5 s at 12 MHz), grants the display to one of two requesters, round-robin, and latches that requester's binary value.
- Converts the value to three BCD digits with a sequential double-dabble (shift-add-3) engine, then commits integer, frac1 and frac2 digits atomically for the display driver.
- The display shows X.YZ, so the input is in hundredths (0..999).

---
 rtl/display_update_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_display_update_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_update_scheduler
// Description : Arbitrates the 3-digit seven-segment display between two
//               measurement sources. On every refresh tick one requester is
//               granted (round-robin under contention), its binary value in
//               hundredths is latched and clamped to 999, converted to BCD
//               with a sequential double-dabble engine, and the three digits
//               are committed to the display driver in a single cycle.
//
// Ports       : clk, rst             clock, synchronous active-high reset
//               src0_req/data/ack    source 0 request level, value, capture pulse
//               src1_req/data/ack    source 1 request level, value, capture pulse
//               hold                 defers new grants while high
//               integer_data         BCD hundreds digit (before decimal point)
//               float1_data          BCD tens digit
//               float2_data          BCD units digit
//               active_src           source of the digits on display
//               ovf                  displayed value was clamped to 999
//               upd_strobe           one-cycle pulse when the digits change
//               busy                 conversion or commit in progress
//
// Revision    : 1.0 - initial release
// ============================================================================
module display_update_scheduler #(
    parameter int REFRESH_CYCLES = 6000000,
    parameter int BIN_W          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src0_req,
    input  logic [BIN_W-1:0] src0_data,
    output logic             src0_ack,
    input  logic             src1_req,
    input  logic [BIN_W-1:0] src1_data,
    output logic             src1_ack,
    input  logic             hold,
    output logic [3:0]       integer_data,
    output logic [3:0]       float1_data,
    output logic [3:0]       float2_data,
    output logic             active_src,
    output logic             ovf,
    output logic             upd_strobe,
    output logic             busy
);

    localparam int                c_TW    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_TW-1:0]   c_TMAX  = c_TW'(REFRESH_CYCLES - 1);
    localparam logic [4:0]        c_CLAST = 5'(BIN_W - 1);
    localparam logic [BIN_W-1:0]  c_MAX   = BIN_W'(999);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [c_TW-1:0]  r_timer;
    logic             r_pending;
    logic             r_last_src;
    logic [BIN_W-1:0] r_bin;
    logic [11:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic             r_src;
    logic             r_clamp;

    logic             r_ack0;
    logic             r_ack1;
    logic [3:0]       r_int;
    logic [3:0]       r_f1;
    logic [3:0]       r_f2;
    logic             r_active;
    logic             r_ovf;
    logic             r_strobe;

    logic             w_tick;
    logic             w_grant;
    logic             w_gsel;
    logic [BIN_W-1:0] w_data_sel;
    logic             w_over;
    logic [BIN_W-1:0] w_clamped;
    logic [10:0]      w_bcd_adj;

    function automatic logic [3:0] f_adj(input logic [3:0] nib);
        f_adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // ------------------------------------------------------------------
    // Grant and arbitration
    // ------------------------------------------------------------------
    assign w_tick  = (r_timer == c_TMAX);
    assign w_grant = (r_state == S_IDLE) && r_pending && !hold && (src0_req || src1_req);
    // Both requesting: the source that did not win last time. Otherwise
    // whichever one is requesting.
    assign w_gsel     = (src0_req && src1_req) ? ~r_last_src : src1_req;
    assign w_data_sel = w_gsel ? src1_data : src0_data;
    assign w_over     = (32'(w_data_sel) > 32'd999);
    assign w_clamped  = w_over ? c_MAX : w_data_sel;

    // Hundreds nibble never reaches 5 before a shift: with the input clamped
    // to 999 every partial prefix is at most 499. Only the lower two nibbles
    // need the add-3 correction, and bit 11 is never shifted out as a 1.
    assign w_bcd_adj = {r_bcd[10:8], f_adj(r_bcd[7:4]), f_adj(r_bcd[3:0])};

    // ------------------------------------------------------------------
    // Refresh timer and pending tick (ticks merge while pending)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + 1'b1;
            // A tick coinciding with a grant belongs to the next refresh.
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (w_grant) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_grant) w_state_nxt = S_CONVERT;
            S_CONVERT: if (r_cnt == c_CLAST) w_state_nxt = S_COMMIT;
            S_COMMIT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture, double-dabble, commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_src <= 1'b1;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_src      <= 1'b0;
            r_clamp    <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_int      <= '0;
            r_f1       <= '0;
            r_f2       <= '0;
            r_active   <= 1'b0;
            r_ovf      <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_bin      <= w_clamped;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_src      <= w_gsel;
                        r_clamp    <= w_over;
                        r_last_src <= w_gsel;
                        r_ack0     <= ~w_gsel;
                        r_ack1     <= w_gsel;
                    end
                end
                S_CONVERT: begin
                    r_bcd <= {w_bcd_adj, r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_COMMIT: begin
                    r_int    <= r_bcd[11:8];
                    r_f1     <= r_bcd[7:4];
                    r_f2     <= r_bcd[3:0];
                    r_active <= r_src;
                    r_ovf    <= r_clamp;
                    r_strobe <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign src0_ack     = r_ack0;
    assign src1_ack     = r_ack1;
    assign integer_data = r_int;
    assign float1_data  = r_f1;
    assign float2_data  = r_f2;
    assign active_src   = r_active;
    assign ovf          = r_ovf;
    assign upd_strobe   = r_strobe;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_display_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_update_scheduler
// Description : Self-checking bench for display_update_scheduler. Expected
//               display updates are queued when a request is issued and
//               checked against each upd_strobe; table rows cover single
//               requests, multi-cycle sequences cover contention, hold,
//               idle periods and reset during conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_update_scheduler;

    localparam int RC = 16;
    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src0_req = 1'b0;
    logic [BW-1:0] src0_data = '0;
    logic          src0_ack;
    logic          src1_req = 1'b0;
    logic [BW-1:0] src1_data = '0;
    logic          src1_ack;
    logic          hold = 1'b0;
    logic [3:0]    integer_data;
    logic [3:0]    float1_data;
    logic [3:0]    float2_data;
    logic          active_src;
    logic          ovf;
    logic          upd_strobe;
    logic          busy;

    always #5 clk = ~clk;

    display_update_scheduler #(
        .REFRESH_CYCLES(RC),
        .BIN_W         (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src0_req    (src0_req),
        .src0_data   (src0_data),
        .src0_ack    (src0_ack),
        .src1_req    (src1_req),
        .src1_data   (src1_data),
        .src1_ack    (src1_ack),
        .hold        (hold),
        .integer_data(integer_data),
        .float1_data (float1_data),
        .float2_data (float2_data),
        .active_src  (active_src),
        .ovf         (ovf),
        .upd_strobe  (upd_strobe),
        .busy        (busy)
    );

    typedef struct packed {
        logic [3:0] d_int;
        logic [3:0] d_f1;
        logic [3:0] d_f2;
        logic       src;
        logic       ovf;
    } exp_t;

    typedef struct packed {
        logic          src;
        logic [BW-1:0] data;
        exp_t          exp;
    } vec_t;

    exp_t       q[$];
    exp_t       mon_exp;
    exp_t       mon_got;
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         mon_en  = 1'b0;
    logic [11:0] prev_dig = '0;

    // ------------------------------------------------------------------
    // Display monitor: every strobe must match the oldest expectation and
    // the digits may only change together with a strobe.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            if ({integer_data, float1_data, float2_data} != prev_dig) begin
                n_tests++;
                if (!upd_strobe) begin
                    n_fail++;
                    $display("FAIL digits_change_no_strobe: got %h was %h",
                             {integer_data, float1_data, float2_data}, prev_dig);
                end
            end
            if (upd_strobe) begin
                n_tests++;
                mon_got = '{integer_data, float1_data, float2_data, active_src, ovf};
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: got digits %0d%0d%0d src=%0d ovf=%0d, none expected",
                             integer_data, float1_data, float2_data, active_src, ovf);
                end else begin
                    mon_exp = q.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_fail++;
                        $display("FAIL display_update: got %0d%0d%0d src=%0d ovf=%0d, expected %0d%0d%0d src=%0d ovf=%0d",
                                 mon_got.d_int, mon_got.d_f1, mon_got.d_f2, mon_got.src, mon_got.ovf,
                                 mon_exp.d_int, mon_exp.d_f1, mon_exp.d_f2, mon_exp.src, mon_exp.ovf);
                    end
                end
            end
        end
        prev_dig = {integer_data, float1_data, float2_data};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits for any ack, checks it came from source s; cyc = negedges waited.
    task automatic wait_ack(input logic s, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 4 * RC; i++) begin
            @(negedge clk);
            if (src0_ack || src1_ack) begin
                cyc = i;
                check("ack_source", {30'd0, src1_ack, src0_ack}, s ? 32'd2 : 32'd1);
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL ack_timeout: no ack within %0d cycles, wanted src%0d", 4 * RC, s);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * RC; i++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL update_timeout: %0d expected updates never shown", q.size());
        q.delete();
    endtask

    vec_t vecs[8];

    initial begin
        int   cyc;
        int   lat;
        int   busy_cnt;
        int   acks;
        logic model_last;
        logic g;

        vecs[0] = '{1'b0, 10'd347,  '{4'd3, 4'd4, 4'd7, 1'b0, 1'b0}};
        vecs[1] = '{1'b1, 10'd1023, '{4'd9, 4'd9, 4'd9, 1'b1, 1'b1}};
        vecs[2] = '{1'b1, 10'd5,    '{4'd0, 4'd0, 4'd5, 1'b1, 1'b0}};
        vecs[3] = '{1'b0, 10'd999,  '{4'd9, 4'd9, 4'd9, 1'b0, 1'b0}};
        vecs[4] = '{1'b1, 10'd1000, '{4'd9, 4'd9, 4'd9, 1'b1, 1'b1}};
        vecs[5] = '{1'b0, 10'd0,    '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0}};
        vecs[6] = '{1'b1, 10'd42,   '{4'd0, 4'd4, 4'd2, 1'b1, 1'b0}};
        vecs[7] = '{1'b0, 10'd100,  '{4'd1, 4'd0, 4'd0, 1'b0, 1'b0}};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("reset_digits", {20'd0, integer_data, float1_data, float2_data}, 32'd0);
        check("reset_flags", {26'd0, src0_ack, src1_ack, upd_strobe, ovf, busy, active_src}, 32'd0);

        // ---------------- first transaction, exact timing ----------------
        rst       = 1'b0;
        mon_en    = 1'b1;
        src0_req  = 1'b1;
        src0_data = 10'd347;
        q.push_back('{4'd3, 4'd4, 4'd7, 1'b0, 1'b0});
        wait_ack(1'b0, cyc);
        src0_req = 1'b0;
        check("first_ack_cycle", cyc, RC + 1);
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) check("ack_one_cycle", {31'd0, src0_ack}, 32'd0);
            if (upd_strobe) begin
                lat = k;
                check("busy_low_at_commit", {31'd0, busy}, 32'd0);
                break;
            end
            if (busy) busy_cnt++;
        end
        check("commit_latency", lat, BW + 1);
        check("busy_cycles", busy_cnt, BW + 1);
        @(negedge clk);
        check("strobe_one_cycle", {31'd0, upd_strobe}, 32'd0);
        model_last = 1'b0;

        // ---------------- table-driven single requests ----------------
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].src) begin
                src1_req  = 1'b1;
                src1_data = vecs[i].data;
            end else begin
                src0_req  = 1'b1;
                src0_data = vecs[i].data;
            end
            q.push_back(vecs[i].exp);
            wait_ack(vecs[i].src, cyc);
            src0_req = 1'b0;
            src1_req = 1'b0;
            drain();
            model_last = vecs[i].src;
        end

        // ---------------- sustained contention, round-robin ----------------
        src0_data = 10'd125;
        src1_data = 10'd680;
        src0_req  = 1'b1;
        src1_req  = 1'b1;
        for (int r = 0; r < 4; r++) begin
            g = ~model_last;
            if (g) q.push_back('{4'd6, 4'd8, 4'd0, 1'b1, 1'b0});
            else   q.push_back('{4'd1, 4'd2, 4'd5, 1'b0, 1'b0});
            wait_ack(g, cyc);
            if (r == 3) begin
                src0_req = 1'b0;
                src1_req = 1'b0;
            end
            model_last = g;
        end
        drain();

        // ---------------- hold defers grant across ticks ----------------
        hold      = 1'b1;
        src0_req  = 1'b1;
        src0_data = 10'd555;
        acks = 0;
        repeat (3 * RC) begin
            @(negedge clk);
            if (src0_ack || src1_ack) acks++;
        end
        check("acks_during_hold", acks, 0);
        q.push_back('{4'd5, 4'd5, 4'd5, 1'b0, 1'b0});
        hold = 1'b0;
        @(negedge clk);
        check("ack_after_hold", {30'd0, src1_ack, src0_ack}, 32'd1);
        src0_req = 1'b0;
        drain();
        repeat (2 * RC) @(negedge clk);

        // ---------------- idle ticks, then a late request ----------------
        repeat (5 * RC) @(negedge clk);
        src1_req  = 1'b1;
        src1_data = 10'd42;
        q.push_back('{4'd0, 4'd4, 4'd2, 1'b1, 1'b0});
        @(negedge clk);
        check("late_req_ack", {30'd0, src1_ack, src0_ack}, 32'd2);
        src1_req = 1'b0;
        drain();

        // ---------------- reset during conversion ----------------
        src0_req  = 1'b1;
        src0_data = 10'd999;
        wait_ack(1'b0, cyc);
        src0_req = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("abort_digits", {20'd0, integer_data, float1_data, float2_data}, 32'd0);
        check("abort_flags", {26'd0, src0_ack, src1_ack, upd_strobe, ovf, busy, active_src}, 32'd0);
        rst = 1'b0;
        acks = 0;
        repeat (2 * RC) begin
            @(negedge clk);
            if (upd_strobe || src0_ack || src1_ack) acks++;
        end
        check("no_activity_after_abort", acks, 0);
        mon_en = 1'b1;

        // Resume; after reset src0 wins the first contention.
        src1_req  = 1'b1;
        src1_data = 10'd680;
        q.push_back('{4'd6, 4'd8, 4'd0, 1'b1, 1'b0});
        wait_ack(1'b1, cyc);
        src1_req = 1'b0;
        drain();
        rst = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_en    = 1'b1;
        src0_req  = 1'b1;
        src1_req  = 1'b1;
        src0_data = 10'd125;
        src1_data = 10'd680;
        q.push_back('{4'd1, 4'd2, 4'd5, 1'b0, 1'b0});
        wait_ack(1'b0, cyc);
        src0_req = 1'b0;
        src1_req = 1'b0;
        drain();

        repeat (4) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
